// File: rtl/fft_magnitude_streamer.sv
// fft_magnitude_streamer
//   Accepts one N_POINTS-bin FFT frame over valid/ready, computes a per-bin
//   magnitude estimate max(|re|,|im|) + min(|re|,|im|)/4, buffers it in RAM,
//   then pulses task_done and replays every magnitude, one bin per cycle.
//   Optional build macro: MAG_DC_BLANK_EN (forces bins 0..2 to zero).
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   fft_valid/ready     input handshake; fft_last marks bin N_POINTS-1
//   fft_re, fft_im      signed input sample
//   task_done           1-cycle pulse, bin 0 follows on the next cycle
//   magnitude_data      replayed magnitude, 0 outside playback
//   stream_valid        high while magnitude_data carries bins 0..N_POINTS-1
//   frame_err           1-cycle pulse on fft_last/count mismatch
//   busy                high from end of frame capture through playback
module fft_magnitude_streamer #(
    parameter int unsigned N_POINTS = 2048,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned IN_W     = 16,
    parameter int unsigned MAG_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fft_valid,
    input  logic signed [IN_W-1:0] fft_re,
    input  logic signed [IN_W-1:0] fft_im,
    input  logic                   fft_last,
    output logic                   fft_ready,
    output logic                   task_done,
    output logic [MAG_W-1:0]       magnitude_data,
    output logic                   stream_valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int unsigned ABS_W = IN_W - 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_DRAIN,
        S_ANNOUNCE,
        S_PLAY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   play_cnt_q, play_cnt_d;
    logic                drain_cnt_q, drain_cnt_d;
    logic                fft_ready_q, fft_ready_d;
    logic                task_done_q, task_done_d;
    logic                stream_valid_q, stream_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic [MAG_W-1:0]    mag_out_q, mag_out_d;

    logic                s1_vld_q, s1_vld_d;
    logic [ABS_W-1:0]    s1_a_q, s1_a_d;
    logic [ABS_W-1:0]    s1_b_q, s1_b_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
    logic                s2_vld_q, s2_vld_d;
    logic [MAG_W-1:0]    s2_mag_q, s2_mag_d;
    logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;

    logic                accept_c;
    logic                rd_en_c;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic [ABS_W-1:0]    big_c, small_c;

    logic [MAG_W-1:0]    mem [N_POINTS];

    // Saturating absolute value: the most negative code maps to the largest positive one.
    function automatic logic [ABS_W-1:0] sat_abs(input logic [IN_W-1:0] x);
        logic [IN_W-1:0] neg;
        neg = -x;
        if (!x[IN_W-1])
            sat_abs = x[ABS_W-1:0];
        else if (x[ABS_W-1:0] == '0)
            sat_abs = '1;
        else
            sat_abs = neg[ABS_W-1:0];
    endfunction

    // Frame control FSM: next state, counters and registered-output next values.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        play_cnt_d  = play_cnt_q;
        drain_cnt_d = drain_cnt_q;
        frame_err_d = 1'b0;
        accept_c    = 1'b0;
        rd_en_c     = 1'b0;
        rd_addr_c   = '0;
        unique case (state_q)
            S_FILL: begin
                accept_c = fft_valid && fft_ready_q;
                if (accept_c) begin
                    if (wr_cnt_q == ADDR_W'(N_POINTS - 1)) begin
                        frame_err_d = !fft_last;
                        wr_cnt_d    = '0;
                        drain_cnt_d = 1'b0;
                        state_d     = S_DRAIN;
                    end else if (fft_last) begin
                        // Short frame: discard it and restart indexing.
                        frame_err_d = 1'b1;
                        wr_cnt_d    = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q) state_d = S_ANNOUNCE;
            end
            S_ANNOUNCE: begin
                rd_en_c    = 1'b1;
                rd_addr_c  = '0;
                play_cnt_d = '0;
                state_d    = S_PLAY;
            end
            S_PLAY: begin
                // play_cnt_q is the bin on the output now; fetch the next one.
                play_cnt_d = play_cnt_q + ADDR_W'(1);
                if (play_cnt_q == ADDR_W'(N_POINTS - 1)) begin
                    state_d = S_FILL;
                end else begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = play_cnt_q + ADDR_W'(1);
                end
            end
        endcase
        fft_ready_d    = (state_d == S_FILL);
        busy_d         = (state_d != S_FILL);
        task_done_d    = (state_d == S_ANNOUNCE);
        stream_valid_d = (state_d == S_PLAY);
        mag_out_d      = rd_en_c ? mem[rd_addr_c] : '0;
    end

    // Magnitude pipeline: S1 absolute values, S2 max + min/4.
    always_comb begin
        s1_vld_d  = accept_c;
        s1_a_d    = sat_abs(fft_re);
        s1_b_d    = sat_abs(fft_im);
        s1_addr_d = wr_cnt_q;
        big_c     = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
        small_c   = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        s2_mag_d  = MAG_W'(big_c) + MAG_W'(small_c >> 2);
`ifdef MAG_DC_BLANK_EN
        if (s1_addr_q < ADDR_W'(3)) s2_mag_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_FILL;
            wr_cnt_q       <= '0;
            play_cnt_q     <= '0;
            drain_cnt_q    <= 1'b0;
            fft_ready_q    <= 1'b0;
            task_done_q    <= 1'b0;
            stream_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
            mag_out_q      <= '0;
            s1_vld_q       <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_addr_q      <= '0;
            s2_vld_q       <= 1'b0;
            s2_mag_q       <= '0;
            s2_addr_q      <= '0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            play_cnt_q     <= play_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            fft_ready_q    <= fft_ready_d;
            task_done_q    <= task_done_d;
            stream_valid_q <= stream_valid_d;
            frame_err_q    <= frame_err_d;
            busy_q         <= busy_d;
            mag_out_q      <= mag_out_d;
            s1_vld_q       <= s1_vld_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_addr_q      <= s1_addr_d;
            s2_vld_q       <= s2_vld_d;
            s2_mag_q       <= s2_mag_d;
            s2_addr_q      <= s2_addr_d;
        end
    end

    // Frame buffer write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (s2_vld_q) mem[s2_addr_q] <= s2_mag_q;
    end

    assign fft_ready      = fft_ready_q;
    assign task_done      = task_done_q;
    assign magnitude_data = mag_out_q;
    assign stream_valid   = stream_valid_q;
    assign frame_err      = frame_err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fft_magnitude_streamer.sv
// Directed sequence of frames with random sample data, checked against a
// plain-arithmetic magnitude model and the documented handshake timing.
module tb_fft_magnitude_streamer;

    localparam int N = 2048;
`ifdef MAG_DC_BLANK_EN
    localparam bit DC_BLANK = 1'b1;
`else
    localparam bit DC_BLANK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               fft_valid;
    logic signed [15:0] fft_re;
    logic signed [15:0] fft_im;
    logic               fft_last;
    logic               fft_ready;
    logic               task_done;
    logic [15:0]        magnitude_data;
    logic               stream_valid;
    logic               frame_err;
    logic               busy;

    always #5 clk = ~clk;

    fft_magnitude_streamer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fft_valid      (fft_valid),
        .fft_re         (fft_re),
        .fft_im         (fft_im),
        .fft_last       (fft_last),
        .fft_ready      (fft_ready),
        .task_done      (task_done),
        .magnitude_data (magnitude_data),
        .stream_valid   (stream_valid),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic signed [15:0] re_a [N];
    logic signed [15:0] im_a [N];
    int                 exp_a [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference magnitude from integer arithmetic.
    function automatic int ref_mag(input int re, input int im, input int bin);
        int a, b, hi, lo;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        if (a > 32767) a = 32767;
        if (b > 32767) b = 32767;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        if (DC_BLANK && bin < 3) return 0;
        return hi + lo / 4;
    endfunction

    function automatic logic signed [15:0] rnd16();
        if ($urandom_range(7) == 0) return 16'sh8000;
        return 16'($urandom);
    endfunction

    task automatic random_frame();
        for (int k = 0; k < N; k++) begin
            re_a[k]  = rnd16();
            im_a[k]  = rnd16();
            exp_a[k] = ref_mag(int'(re_a[k]), int'(im_a[k]), k);
        end
    endtask

    // Drive bins 0..n_bins-1 (fft_last on bin last_at); alt inserts an idle cycle every other cycle.
    task automatic feed(input int n_bins, input int last_at, input bit alt);
        int k = 0;
        int cyc = 0;
        while (k < n_bins && cyc < 20000) begin
            @(negedge clk);
            fft_last = 1'b0;
            if (alt && (cyc % 2 == 1)) begin
                fft_valid = 1'b0;
                fft_re    = 16'($urandom);
                fft_im    = 16'($urandom);
            end else begin
                fft_valid = 1'b1;
                fft_re    = re_a[k];
                fft_im    = im_a[k];
                fft_last  = (k == last_at);
                if (fft_ready) k++;
            end
            cyc++;
        end
        check("feed_accepted", 64'(k), 64'(n_bins));
    endtask

    // Follows a full-frame accept: checks latency, the replay, and the return to FILL.
    task automatic playback(input bit exp_err, input bit hold, input int abort_at);
        int lat = 1;
        bit aborted = 1'b0;
        @(negedge clk);
        fft_last  = 1'b0;
        fft_valid = hold;
        fft_re    = 16'($urandom);
        fft_im    = 16'($urandom);
        check("frame_err_after_last", 64'(frame_err), 64'(exp_err));
        check("drain_ready_busy", {fft_ready, busy, stream_valid}, 3'b010);
        while (!task_done && lat < 40) begin
            @(negedge clk);
            lat++;
            fft_re = 16'($urandom);
            fft_im = 16'($urandom);
        end
        check("task_done_latency", 64'(lat), 64'd3);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            fft_re = 16'($urandom);
            fft_im = 16'($urandom);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("async_reset_outputs",
                      {stream_valid, magnitude_data, task_done, busy, fft_ready, frame_err}, '0);
                aborted = 1'b1;
                break;
            end
            check($sformatf("bin%0d", k),
                  {stream_valid, fft_ready, task_done, busy, magnitude_data},
                  {1'b1, 1'b0, 1'b0, 1'b1, 16'(exp_a[k])});
        end
        if (!aborted) begin
            @(negedge clk);
            fft_valid = 1'b0;
            check("end_of_play",
                  {stream_valid, fft_ready, task_done, busy, magnitude_data},
                  {1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        end
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        fft_valid = 1'b0;
        fft_re    = '0;
        fft_im    = '0;
        fft_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {fft_ready, task_done, magnitude_data, stream_valid, frame_err, busy}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {fft_ready, busy}, 2'b10);

        // Constant tone, continuous valid.
        for (int k = 0; k < N; k++) begin
            re_a[k]  = 16'sd1000;
            im_a[k]  = 16'sd0;
            exp_a[k] = (DC_BLANK && k < 3) ? 0 : 1000;
        end
        feed(N, N - 1, 1'b0);
        playback(1'b0, 1'b0, -1);

        // Two isolated bins: a 3-4-5 triangle and full-scale negative saturation.
        for (int k = 0; k < N; k++) begin
            re_a[k]  = 16'sd0;
            im_a[k]  = 16'sd0;
            exp_a[k] = 0;
        end
        re_a[5] = 16'sd300;
        im_a[5] = 16'sd400;
        exp_a[5] = 475;
        re_a[7] = 16'sh8000;
        im_a[7] = 16'sh8000;
        exp_a[7] = 40958;
        feed(N, N - 1, 1'b0);
        playback(1'b0, 1'b0, -1);

        // Early fft_last: error pulse, frame dropped, no announcement.
        random_frame();
        feed(1001, 1000, 1'b0);
        @(negedge clk);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        check("short_frame_err", {frame_err, fft_ready, busy}, 3'b110);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= task_done | stream_valid | frame_err | busy;
        end
        check("short_frame_quiet", 64'(seen), 64'd0);
        random_frame();
        feed(N, N - 1, 1'b0);
        playback(1'b0, 1'b0, -1);

        // Gappy input, valid held through playback; next frame proves nothing was swallowed.
        random_frame();
        feed(N, N - 1, 1'b1);
        playback(1'b0, 1'b1, -1);
        random_frame();
        feed(N, N - 1, 1'b0);
        playback(1'b0, 1'b0, -1);

        // Missing fft_last on the final bin: error pulse, frame still replayed.
        random_frame();
        feed(N, -1, 1'b0);
        playback(1'b1, 1'b0, -1);

        // Reset during playback, then a clean frame.
        random_frame();
        feed(N, N - 1, 1'b0);
        playback(1'b0, 1'b0, 600);
        fft_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle",
              {fft_ready, task_done, stream_valid, busy, frame_err, magnitude_data},
              {1'b1, 4'b0000, 16'h0});
        random_frame();
        feed(N, N - 1, 1'b0);
        playback(1'b0, 1'b0, -1);

        // Low bins carrying energy (blanked when the DC option is built in).
        random_frame();
        for (int k = 0; k < 4; k++) begin
            re_a[k]  = 16'sd5000;
            im_a[k]  = 16'sd0;
            exp_a[k] = (DC_BLANK && k < 3) ? 0 : 5000;
        end
        feed(N, N - 1, 1'b0);
        playback(1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
